// File: rtl/sipo_frame_deserializer_pkg.sv
// Shared constants for the serial frame deserializer: FSM encodings and default
// word/sync geometry used by the serial blocks.
package sipo_frame_deserializer_pkg;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_LEN    = 8;
  localparam int unsigned DEF_FRAME_WORDS = 4;
  localparam logic [7:0]  DEF_SYNC_PATTERN = 8'hD5;

endpackage

// File: rtl/sipo_frame_deserializer_sipo_shift.sv
// Right-shifting serial-in/parallel-out register; the newest bit enters at the MSB
// so the first-received bit ends up at bit 0 once N bits have been shifted in.
module sipo_shift #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         si,
  output logic [N-1:0] q
);

  // clr wins over en so a match/frame-end edge leaves the register empty
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= {si, q[N-1:1]};
  end

endmodule

// File: rtl/sipo_frame_deserializer.sv
// Serial frame deserializer: hunts for a sync word, then assembles FRAME_WORDS
// LSB-first words into a valid/ready holding register.
module sipo_frame_deserializer
  import sipo_frame_deserializer_pkg::*;
#(
  parameter int unsigned          WIDTH        = DEF_WIDTH,
  parameter int unsigned          SYNC_LEN     = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0]  SYNC_PATTERN = DEF_SYNC_PATTERN,
  parameter int unsigned          FRAME_WORDS  = DEF_FRAME_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             overflow
);

  localparam int unsigned FILL_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned BIT_W  = $clog2(WIDTH + 1);
  localparam int unsigned WORD_W = $clog2(FRAME_WORDS + 1);

  logic [0:0]          state_q;
  logic [FILL_W-1:0]   fill_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [WORD_W-1:0]   word_cnt_q;

  logic [SYNC_LEN-1:0] h_q;
  logic [SYNC_LEN-1:0] h_next;
  logic [WIDTH-1:0]    d_q;
  logic [WIDTH-1:0]    word;

  logic hunt_en, data_en;
  logic fill_full_next, sync_hit;
  logic word_done, frame_done;
  logic accept, load;

  assign hunt_en = si_en && (state_q == ST_HUNT);
  assign data_en = si_en && (state_q == ST_LOCKED);

  // Match is judged on the post-shift window, so the bit arriving now counts
  assign h_next         = {si, h_q[SYNC_LEN-1:1]};
  assign fill_full_next = (fill_q >= FILL_W'(SYNC_LEN - 1));
  assign sync_hit       = hunt_en && fill_full_next && (h_next == SYNC_PATTERN);

  assign word       = {si, d_q[WIDTH-1:1]};
  assign word_done  = data_en && (bit_cnt_q == BIT_W'(WIDTH - 1));
  assign frame_done = word_done && (word_cnt_q == WORD_W'(FRAME_WORDS - 1));

  assign accept = out_valid && out_ready;
  assign load   = word_done && (!out_valid || out_ready);

  assign locked = (state_q == ST_LOCKED);

  sipo_shift #(.N(SYNC_LEN)) u_hunt_shift (
    .clk (clk),
    .rst (rst),
    .en  (hunt_en),
    .clr (sync_hit || frame_done),
    .si  (si),
    .q   (h_q)
  );

  sipo_shift #(.N(WIDTH)) u_data_shift (
    .clk (clk),
    .rst (rst),
    .en  (data_en),
    .clr (sync_hit),
    .si  (si),
    .q   (d_q)
  );

  // FSM and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            state_q    <= ST_LOCKED;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
          end else if (hunt_en && (fill_q < FILL_W'(SYNC_LEN))) begin
            fill_q <= fill_q + FILL_W'(1);
          end
        end
        ST_LOCKED: begin
          if (word_done) begin
            bit_cnt_q <= '0;
            if (frame_done) begin
              state_q    <= ST_HUNT;
              word_cnt_q <= '0;
              fill_q     <= '0;
            end else begin
              word_cnt_q <= word_cnt_q + WORD_W'(1);
            end
          end else if (data_en) begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  // Holding register: a word that completes while the previous one is still
  // pending and not being accepted is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (word_done && !load) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Self-checking bench: bit-queue reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_sipo_frame_deserializer;

  localparam int W   = 8;
  localparam int SL  = 8;
  localparam int FW  = 4;
  localparam logic [7:0] PAT = 8'hD5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic si = 1'b0;
  logic si_en = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic out_valid, locked, overflow;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit       m_locked;
  bit       m_hq[$];
  bit       m_wq[$];
  int       m_words;
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_ovf;

  sipo_frame_deserializer #(
    .WIDTH(W), .SYNC_LEN(SL), .SYNC_PATTERN(PAT), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .rst(rst), .si(si), .si_en(si_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_hq.delete(); m_wq.delete(); m_words = 0;
    m_valid = 0; m_data = 0; m_ovf = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented for it
  task automatic model_edge(input bit r, input bit b, input bit e, input bit rdy);
    bit accept, loaded;
    int v;
    if (r) begin
      model_reset();
      return;
    end
    accept = m_valid && rdy;
    loaded = 0;
    if (e) begin
      if (!m_locked) begin
        m_hq.push_back(b);
        if (m_hq.size() > SL) void'(m_hq.pop_front());
        if (m_hq.size() == SL) begin
          v = 0;
          foreach (m_hq[i]) v += int'(m_hq[i]) << i;
          if (v == int'(PAT)) begin
            m_locked = 1; m_hq.delete(); m_wq.delete(); m_words = 0;
          end
        end
      end else begin
        m_wq.push_back(b);
        if (m_wq.size() == W) begin
          v = 0;
          foreach (m_wq[i]) v += int'(m_wq[i]) << i;
          m_wq.delete();
          if (!m_valid || accept) begin
            m_data = 8'(v); loaded = 1;
          end else begin
            m_ovf = 1;
          end
          m_words++;
          if (m_words == FW) begin
            m_locked = 0; m_words = 0; m_hq.delete();
          end
        end
      end
    end
    if (loaded) m_valid = 1;
    else if (accept) m_valid = 0;
  endtask

  // One clock: drive, clock, update model, compare 1 unit after the edge
  task automatic step(input bit r, input bit b, input bit e, input bit rdy);
    rst = r; si = b; si_en = e; out_ready = rdy;
    @(posedge clk);
    model_edge(r, b, e, rdy);
    #1;
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("locked",    int'(locked),    int'(m_locked));
    chk("overflow",  int'(overflow),  int'(m_ovf));
    chk("out_data",  int'(out_data),  int'(m_data));
  endtask

  task automatic send_byte(input logic [7:0] byt, input bit rdy);
    for (int i = 0; i < 8; i++) step(1'b0, byt[i], 1'b1, rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    logic [7:0] seq [4];
    logic [7:0] bv;
    model_reset();
    #1;

    // 1: reset with random si
    step(1'b1, 1'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'($urandom), 1'b1, 1'b0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_data", int'(out_data), 0);

    // 2: lock then a full frame with ready=1
    bv = PAT;
    for (int i = 0; i < 7; i++) step(1'b0, bv[i], 1'b1, 1'b1);
    chk("lock_early", int'(locked), 0);
    step(1'b0, bv[7], 1'b1, 1'b1);
    chk("lock_rise", int'(locked), 1);
    seq[0] = 8'h3C; seq[1] = 8'hA7; seq[2] = 8'h01; seq[3] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      bv = seq[k];
      for (int i = 0; i < 7; i++) step(1'b0, bv[i], 1'b1, 1'b1);
      chk("word_not_yet", int'(out_valid), 0);
      step(1'b0, bv[7], 1'b1, 1'b1);
      chk("word_valid", int'(out_valid), 1);
      chk("word_data", int'(out_data), int'(seq[k]));
    end
    chk("frame_unlock", int'(locked), 0);

    // 3: false sync, then offset real sync
    do_reset();
    send_byte(8'hD4, 1'b1);
    chk("no_lock_d4", int'(locked), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'hD5, 1'b1);
    chk("lock_d5", int'(locked), 1);
    send_byte(8'h5A, 1'b1);
    chk("first_5a", int'(out_data), 8'h5A);
    chk("first_5a_v", int'(out_valid), 1);

    // 4: backpressure and overflow
    do_reset();
    send_byte(8'hD5, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("bp_data", int'(out_data), 8'h11);
    chk("bp_ovf", int'(overflow), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_accept", int'(out_valid), 0);
    chk("bp_ovf_sticky", int'(overflow), 1);

    // 5: enable gaps inside a word
    do_reset();
    send_byte(8'hD5, 1'b1);
    bv = 8'h6E;
    for (int i = 0; i < 4; i++) step(1'b0, bv[i], 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b0, 1'b1);
    for (int i = 4; i < 7; i++) step(1'b0, bv[i], 1'b1, 1'b1);
    chk("gap_not_yet", int'(out_valid), 0);
    step(1'b0, bv[7], 1'b1, 1'b1);
    chk("gap_data", int'(out_data), 8'h6E);
    chk("gap_valid", int'(out_valid), 1);

    // 6: reset in the middle of a word
    do_reset();
    send_byte(8'hD5, 1'b1);
    bv = 8'h99;
    for (int i = 0; i < 5; i++) step(1'b0, bv[i], 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    send_byte(8'hD5, 1'b1);
    send_byte(8'h42, 1'b1);
    chk("mid_rst_data", int'(out_data), 8'h42);

    // randomized traffic with frequent sync words
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bv = ($urandom_range(0, 3) == 0) ? PAT : 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        while ($urandom_range(0, 4) == 0)
          step(1'b0, 1'($urandom), 1'b0, 1'($urandom));
        step(($urandom_range(0, 999) == 0), bv[i], 1'b1,
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
